winograd_tile_sched: RTL and testbench
======================================

WINOGRAD_TILE_SCHED -- requirements
Module: winograd_tile_sched

Interface
REQ-001 Parameter: ROW_LEN, default 8, samples per frame; even, 4..254.
REQ-002 Parameter: CORE_LAT, default 6, fixed cycles from wc_d to valid wc_z.
REQ-003 Parameter: OBUF_TILES, default 4, result buffer depth in tiles (2 results each).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame when idle, ignored otherwise.
REQ-007 in_data  in  10  signed two's-complement input sample.
REQ-008 in_valid / in_ready  in / out  1 each  input handshake; a sample transfers when both are high.
REQ-009 wc_d  out  40  window to the F(2,3) core: {x0,x1,x2,x3}, x0 (oldest) in [39:30].
REQ-010 wc_z  in  20  core result {y0,y1}, y0 in [19:10], sampled CORE_LAT cycles after issue.
REQ-011 out_data  out  10  signed result sample, y0 before y1.
REQ-012 out_valid / out_ready  out / in  1 each  output handshake.
REQ-013 out_last  out  1  high with the final result of a frame.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle pulse when a frame fully drains.

Function
REQ-016 FSM states: IDLE, FILL, RUN, DRAIN.
- IDLE->FILL on start.
- FILL->RUN after 4 samples accepted.
- RUN->DRAIN after ROW_LEN samples accepted.
- DRAIN->IDLE with done when no tile is in flight and the buffer is empty.
REQ-017 Window: 4-entry shift register; each accepted sample shifts in at x3.
REQ-018 Tile issue: first tile when the 4th sample is accepted, then one tile per 2 further samples (stride 2, overlap 2); tiles per frame = (ROW_LEN-2)/2.
REQ-019 wc_d holds the issued window stable until the next issue; the issue cycle drives the window including the just-accepted sample.
REQ-020 Valid pipeline: a CORE_LAT-deep shift register tracks issued tiles; its output writes wc_z into the result buffer as two entries, y0 then y1.
REQ-021 Credit: in_ready is high only in FILL/RUN and only when (tiles in flight + tiles buffered) < OBUF_TILES, checked before the issue-completing sample is accepted; outside FILL/RUN in_ready is 0.
REQ-022 The result buffer never overflows; out_data/out_valid/out_last come from its head; an entry pops on out_valid&&out_ready.
REQ-023 The core must not be stalled; the datapath passes results through unmodified (10-bit, no saturation).
REQ-024 Simultaneous buffer write and pop in one cycle are both honoured.
REQ-025 A start pulse during busy is ignored; in_valid in IDLE/DRAIN is ignored and no sample is consumed.
REQ-026 out_last is asserted on result number ROW_LEN-2 of the frame only.

Reset
REQ-027 rst low asynchronously clears everything, including mid-frame and mid-drain:
- FSM to IDLE, window to 0, wc_d = 0.
- Valid pipeline and buffer emptied; in-flight results are discarded.
- in_ready, out_valid, out_last, busy and done = 0; out_data = 0.
REQ-028 After rst rises, first start is accepted on the next clk edge.

Verification
REQ-029 ROW_LEN=4 with real wc core, samples 2,-10,3,4 -> wc_d = 0000000010_1111110110_0000000011_0000000100, out_data 37 then 15, out_last on 15, done 1 cycle after the pop.
REQ-030 ROW_LEN=4, samples -19,-6,3,-9 -> out_data -43 then -138; busy low after done.
REQ-031 ROW_LEN=8, continuous in_valid, out_ready=1 -> 3 tiles issued after samples 4, 6 and 8, 6 results matching the golden model, in_ready never low in RUN.
REQ-032 ROW_LEN=8, OBUF_TILES=1, out_ready=0 for 30 cycles -> in_ready drops after the first tile, no result lost, all 6 results correct after out_ready=1.
REQ-033 rst asserted while 2 tiles are in flight -> all outputs 0 within the same cycle; next frame with 2,-10,3,4 yields 37,15 only.
REQ-034 start pulsed mid-frame and in_valid held high in IDLE -> no effect, sample count and results unchanged.

Source files
------------

// File: rtl/winograd_tile_sched.sv
// Tile scheduler for an F(2,3) Winograd core: gathers overlapping 4-sample
// windows, tracks tiles through the fixed-latency core and buffers results.
module winograd_tile_sched #(
  parameter int ROW_LEN    = 8,
  parameter int CORE_LAT   = 6,
  parameter int OBUF_TILES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [9:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [39:0]        wc_d,
  input  logic [19:0]        wc_z,
  output logic signed [9:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int BUF_D = 2 * OBUF_TILES;
  localparam int PW    = $clog2(BUF_D);
  localparam int CW    = $clog2(BUF_D + 1);
  localparam int TW    = CW + 1;
  localparam int SW    = $clog2(ROW_LEN + 1);
  localparam int RW    = $clog2(ROW_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [SW-1:0]   smp_cnt_r;
  logic [RW-1:0]   res_cnt_r;
  logic [39:0]     win_r, win_nxt_s, wc_d_r;
  logic [CORE_LAT-1:0] vpipe_r;
  logic [TW-1:0]   inflight_r, inflight_nxt_s, credit_s, cnt_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [9:0]      obuf_r [BUF_D];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic            in_ready_r, busy_r, done_r;
  logic            acc_s, issue_s, wb_s, pop_s, ready_nxt_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_D - 1)) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  // Next-state, handshake and credit evaluation
  always_comb begin
    acc_s          = in_valid && in_ready_r;
    issue_s        = acc_s && (smp_cnt_r >= SW'(3)) && smp_cnt_r[0];
    wb_s           = vpipe_r[CORE_LAT-1];
    pop_s          = (cnt_r != {CW{1'b0}}) && out_ready;
    win_nxt_s      = {win_r[29:0], in_data};
    inflight_nxt_s = inflight_r + TW'(issue_s) - TW'(wb_s);
    cnt_nxt_s      = TW'(cnt_r) + (wb_s ? TW'(2) : TW'(0)) - TW'(pop_s);
    // a partly drained tile still occupies a whole tile slot
    credit_s       = inflight_nxt_s + ((cnt_nxt_s + TW'(1)) >> 1);
    state_nxt_s    = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = FILL;
        else       state_nxt_s = IDLE;
      end
      FILL, RUN: begin
        if (acc_s && smp_cnt_r == SW'(ROW_LEN - 1))                 state_nxt_s = DRAIN;
        else if (acc_s && state_r == FILL && smp_cnt_r == SW'(3))   state_nxt_s = RUN;
        else                                                        state_nxt_s = state_r;
      end
      DRAIN: begin
        if (inflight_r == TW'(0) && cnt_r == CW'(0)) state_nxt_s = IDLE;
        else                                         state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
    ready_nxt_s = ((state_nxt_s == FILL) || (state_nxt_s == RUN)) &&
                  (credit_s < TW'(OBUF_TILES));
  end

  // Frame FSM, counters, window and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      smp_cnt_r  <= {SW{1'b0}};
      res_cnt_r  <= {RW{1'b0}};
      win_r      <= 40'd0;
      wc_d_r     <= 40'd0;
      vpipe_r    <= {CORE_LAT{1'b0}};
      inflight_r <= {TW{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= inflight_nxt_s;
      in_ready_r <= ready_nxt_s;
      vpipe_r    <= {vpipe_r[CORE_LAT-2:0], issue_s};
      done_r     <= (state_r == DRAIN) && (state_nxt_s == IDLE);
      if (state_r == IDLE && start) begin
        busy_r    <= 1'b1;
        smp_cnt_r <= {SW{1'b0}};
        res_cnt_r <= {RW{1'b0}};
      end else begin
        if (state_r == DRAIN && state_nxt_s == IDLE) busy_r <= 1'b0;
        if (acc_s) smp_cnt_r <= smp_cnt_r + SW'(1);
        if (pop_s) res_cnt_r <= res_cnt_r + RW'(1);
      end
      if (acc_s)   win_r  <= win_nxt_s;
      if (issue_s) wc_d_r <= win_nxt_s;
    end
  end

  // Result buffer: two entries written per tile, one popped per handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_D; i++) obuf_r[i] <= 10'd0;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s[CW-1:0];
      if (wb_s) begin
        obuf_r[wr_ptr_r]          <= wc_z[19:10];
        obuf_r[ptr_inc(wr_ptr_r)] <= wc_z[9:0];
        wr_ptr_r                  <= ptr_inc(ptr_inc(wr_ptr_r));
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  assign in_ready  = in_ready_r;
  assign wc_d      = wc_d_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = (cnt_r != {CW{1'b0}});
  assign out_data  = out_valid ? obuf_r[rd_ptr_r] : 10'sd0;
  assign out_last  = out_valid && (res_cnt_r == RW'(ROW_LEN - 3));

endmodule

// File: tb/tb_winograd_tile_sched.sv
// Bench for winograd_tile_sched: three configurations, a behavioural F(2,3)
// core with taps (4,1,13), and a sliding 3-tap FIR reference of each frame.
module tb_winograd_tile_sched;
  localparam int CL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] start_v, in_valid_v, out_ready_v;
  logic signed [9:0] in_data;
  logic [2:0] in_ready_v, out_valid_v, out_last_v, busy_v, done_v;
  logic [39:0] wc_d_v [3];
  logic [19:0] wc_z_v [3];
  logic [9:0] out_data_v [3];
  logic [19:0] cp [3][CL-1];

  int total = 0;
  int bad = 0;
  logic signed [9:0] smp [$];
  logic [9:0] expq [$];

  winograd_tile_sched #(.ROW_LEN(4), .CORE_LAT(CL), .OBUF_TILES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .wc_d(wc_d_v[0]),
    .wc_z(wc_z_v[0]), .out_data(out_data_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_last(out_last_v[0]), .busy(busy_v[0]),
    .done(done_v[0]));
  winograd_tile_sched #(.ROW_LEN(8), .CORE_LAT(CL), .OBUF_TILES(4)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .wc_d(wc_d_v[1]),
    .wc_z(wc_z_v[1]), .out_data(out_data_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_last(out_last_v[1]), .busy(busy_v[1]),
    .done(done_v[1]));
  winograd_tile_sched #(.ROW_LEN(8), .CORE_LAT(CL), .OBUF_TILES(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_data(in_data),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .wc_d(wc_d_v[2]),
    .wc_z(wc_z_v[2]), .out_data(out_data_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_last(out_last_v[2]), .busy(busy_v[2]),
    .done(done_v[2]));

  function automatic logic [9:0] fir3(input logic signed [9:0] a, b, c);
    logic signed [15:0] acc;
    acc = 16'sd4 * a + b + 16'sd13 * c;
    return acc[9:0];
  endfunction

  // external core: result for the presented window CL-1 clocks later
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cp[k][0] <= {fir3(wc_d_v[k][39:30], wc_d_v[k][29:20], wc_d_v[k][19:10]),
                   fir3(wc_d_v[k][29:20], wc_d_v[k][19:10], wc_d_v[k][9:0])};
      for (int j = 1; j < CL - 1; j++) cp[k][j] <= cp[k][j-1];
    end
  end
  assign wc_z_v[0] = cp[0][CL-2];
  assign wc_z_v[1] = cp[1][CL-2];
  assign wc_z_v[2] = cp[2][CL-2];

  task automatic rand_samples(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(10'($urandom));
  endtask

  task automatic build_exp(input int n);
    expq.delete();
    for (int r = 0; r < n - 2; r++) expq.push_back(fir3(smp[r], smp[r+1], smp[r+2]));
  endtask

  task automatic check_zero(input int k, input string tag);
    total++;
    if ({in_ready_v[k], out_valid_v[k], out_last_v[k], busy_v[k], done_v[k],
         out_data_v[k], wc_d_v[k]} !== 55'd0) begin
      bad++;
      $display("FAIL %s inst=%0d got rdy=%b ov=%b last=%b busy=%b done=%b od=%h wcd=%h want all zero",
               tag, k, in_ready_v[k], out_valid_v[k], out_last_v[k], busy_v[k], done_v[k],
               out_data_v[k], wc_d_v[k]);
    end
  endtask

  // mode 0: streaming, 1: random handshakes + stray starts, 2: output stalled 30 cycles
  task automatic run_frame(input int k, input int n, input int mode);
    int sent, popped, cyc, first_acc, last_acc;
    logic [39:0] exp_win;
    bit have_win;
    sent = 0; popped = 0; cyc = 0; first_acc = -1; last_acc = -1; have_win = 1'b0;
    exp_win = 40'd0;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    total++;
    if (busy_v[k] !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy_v[k]); end
    while (popped < n - 2 && cyc < 3000) begin
      in_valid_v[k]  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data        = (sent < n) ? smp[sent] : 10'($urandom);
      out_ready_v[k] = (mode == 1) ? ($urandom_range(0, 2) != 0) : ((mode == 2) ? (cyc >= 30) : 1'b1);
      start_v[k]     = (mode == 1) && ($urandom_range(0, 15) == 0);
      if (have_win) begin
        total++;
        if (wc_d_v[k] !== exp_win) begin bad++; $display("FAIL wc_d inst=%0d got=%h want=%h", k, wc_d_v[k], exp_win); end
      end
      if (done_v[k] !== 1'b0) begin total++; bad++; $display("FAIL early_done inst=%0d got=1 want=0", k); end
      if (out_valid_v[k]) begin
        total++;
        if (out_last_v[k] !== (popped == n - 3)) begin
          bad++; $display("FAIL out_last inst=%0d idx=%0d got=%b want=%b", k, popped, out_last_v[k], popped == n - 3);
        end
      end
      if (mode == 2 && cyc == 30) begin
        total++;
        if (sent != 4) begin bad++; $display("FAIL credit_stall got=%0d samples want=4", sent); end
      end
      if (in_valid_v[k] && in_ready_v[k]) begin
        if (sent >= n) begin
          total++; bad++; $display("FAIL extra_sample inst=%0d got=%0d want=%0d", k, sent + 1, n);
        end else begin
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          if (sent >= 3 && sent % 2 == 1) begin
            exp_win = {smp[sent-3], smp[sent-2], smp[sent-1], smp[sent]};
            have_win = 1'b1;
          end
          sent++;
        end
      end
      if (out_valid_v[k] && out_ready_v[k]) begin
        total++;
        if (out_data_v[k] !== expq[popped]) begin
          bad++; $display("FAIL result inst=%0d idx=%0d got=%0d want=%0d", k, popped,
                          $signed(out_data_v[k]), $signed(expq[popped]));
        end
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_v[k] = (mode == 0);
    start_v[k] = 1'b0;
    total++;
    if (popped != n - 2) begin bad++; $display("FAIL result_count inst=%0d got=%0d want=%0d", k, popped, n - 2); end
    total++;
    if (sent != n) begin bad++; $display("FAIL sample_count inst=%0d got=%0d want=%0d", k, sent, n); end
    if (mode == 0) begin
      total++;
      if (last_acc - first_acc != n - 1) begin
        bad++; $display("FAIL streaming inst=%0d got=%0d cycles want=%0d", k, last_acc - first_acc, n - 1);
      end
    end
    total++;
    if (done_v[k] !== 1'b0 || in_ready_v[k] !== 1'b0) begin
      bad++; $display("FAIL done_early inst=%0d got done=%b rdy=%b want 0 0", k, done_v[k], in_ready_v[k]);
    end
    @(negedge clk);
    total++;
    if (done_v[k] !== 1'b1) begin bad++; $display("FAIL done_pulse inst=%0d got=%b want=1", k, done_v[k]); end
    @(negedge clk);
    total++;
    if ({done_v[k], busy_v[k], in_ready_v[k], out_valid_v[k]} !== 4'b0000) begin
      bad++; $display("FAIL after_done inst=%0d got done=%b busy=%b rdy=%b ov=%b want 0000",
                      k, done_v[k], busy_v[k], in_ready_v[k], out_valid_v[k]);
    end
    in_valid_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_v = 3'b000; in_valid_v = 3'b000; out_ready_v = 3'b000; in_data = 10'sd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_zero(k, "reset_state");
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        bad++; $display("FAIL idle_ignore got rdy=%b busy=%b want 0 0", in_ready_v[0], busy_v[0]);
      end
    end
    smp = {10'sd2, -10'sd10, 10'sd3, 10'sd4};
    expq = {10'd37, 10'd15};
    run_frame(0, 4, 0);
    total++;
    if (wc_d_v[0] !== 40'b0000000010_1111110110_0000000011_0000000100) begin
      bad++; $display("FAIL wc_d_literal got=%h want=%h", wc_d_v[0], 40'b0000000010_1111110110_0000000011_0000000100);
    end
    smp = {-10'sd19, -10'sd6, 10'sd3, -10'sd9};
    expq = {10'h3D5, 10'h376};
    run_frame(0, 4, 1);
  endtask

  task automatic test_stream();
    rand_samples(8);
    build_exp(8);
    run_frame(1, 8, 0);
  endtask

  task automatic test_credit_stall();
    rand_samples(8);
    build_exp(8);
    run_frame(2, 8, 2);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      int k, n;
      k = it % 3;
      n = (k == 0) ? 4 : 8;
      rand_samples(n);
      build_exp(n);
      run_frame(k, n, 1);
    end
  endtask

  task automatic test_reset_midflight();
    int sent, cyc;
    rand_samples(8);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    in_valid_v[1] = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 6 && cyc < 50) begin
      in_data = smp[sent];
      if (in_ready_v[1]) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid_v[1] = 1'b0;
    total++;
    if (sent != 6 || busy_v[1] !== 1'b1) begin
      bad++; $display("FAIL midflight_setup got sent=%0d busy=%b want 6 1", sent, busy_v[1]);
    end
    rst = 1'b0;
    #1;
    check_zero(1, "async_reset");
    @(negedge clk);
    rst = 1'b1;
    smp = {10'sd2, -10'sd10, 10'sd3, 10'sd4};
    expq = {10'd37, 10'd15};
    run_frame(0, 4, 0);
    rand_samples(8);
    build_exp(8);
    run_frame(1, 8, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_vectors();
    test_stream();
    test_credit_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
